// File: rtl/vga_timing_pkg.sv
// Shared types and helpers for the parametrised VGA timing engine.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ZOOM_1X  = 2'd0,
    ZOOM_2X  = 2'd1,
    ZOOM_4X  = 2'd2,
    ZOOM_RSV = 2'd3
  } zoomModeT;

  // Reserved mode falls back to 1x.
  function automatic logic [1:0] zoomShift(input zoomModeT mode);
    case (mode)
      ZOOM_2X: return 2'd1;
      ZOOM_4X: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic int lineTotal(input int front, input int sync, input int back, input int active);
    return front + sync + back + active;
  endfunction

  function automatic int activeStart(input int front, input int sync, input int back);
    return front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_engine_hv_counter.sv
// Free-running H/V raster counters with frame strobe and frame counter.
module vga_hv_counter #(
  parameter int CNT_W   = 13,
  parameter int FRAME_W = 16,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  output logic [CNT_W-1:0]   oH,
  output logic [CNT_W-1:0]   oV,
  output logic [CNT_W-1:0]   oHNext,
  output logic [CNT_W-1:0]   oVNext,
  output logic               oFrameStart,
  output logic [FRAME_W-1:0] oFrameCnt
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] hR, vR;
  logic             atOrigin;

  // Next raster position; V only advances on the last pixel of a line.
  always_comb begin
    oHNext   = hR + ONE;
    oVNext   = vR;
    atOrigin = (hR == '0) && (vR == '0);
    if (hR == H_LAST) begin
      oHNext = '0;
      if (vR == V_LAST) begin
        oVNext = '0;
      end else begin
        oVNext = vR + ONE;
      end
    end else begin
      oHNext = hR + ONE;
    end
  end

  // Raster position and per-frame bookkeeping.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      hR          <= '0;
      vR          <= '0;
      oFrameStart <= 1'b0;
      oFrameCnt   <= '0;
    end else begin
      hR          <= oHNext;
      vR          <= oVNext;
      oFrameStart <= atOrigin;
      if (atOrigin) begin
        oFrameCnt <= oFrameCnt + FRAME_W'(1);
      end else begin
        oFrameCnt <= oFrameCnt;
      end
    end
  end

  assign oH = hR;
  assign oV = vR;

endmodule

// File: rtl/vga_timing_engine.sv
// Parametrised VGA timing generator with integer zoom, line-buffer FIFO
// handshakes and a frame counter for frame-synchronous updates.
module vga_timing_engine
  import vga_timing_pkg::*;
#(
  parameter int COLOR_W    = 8,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int H_ACTIVE   = 640,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_ACTIVE   = 480,
  parameter int HSYNC_POL  = 1,
  parameter int VSYNC_POL  = 1,
  parameter int LOAD_H_POS = 2,
  parameter int CNT_W      = 13,
  parameter int FRAME_W    = 16
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [1:0]         iZOOM_MODE,
  input  logic [COLOR_W-1:0] iData_R,
  input  logic [COLOR_W-1:0] iData_G,
  input  logic [COLOR_W-1:0] iData_B,
  output logic               oFIFO_RCLK,
  output logic               oFIFO_REQ,
  output logic               oFIFO_LOAD_REQ,
  output logic [CNT_W-1:0]   oFIFO_LOAD_VLINE,
  output logic               oFIFO_CLEAR,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_SYNC_N,
  output logic               oVGA_BLANK_N,
  output logic               oVGA_CLK,
  output logic               oFRAME_START,
  output logic [FRAME_W-1:0] oFRAME_CNT
);

  localparam int H_TOTAL = lineTotal(H_FRONT, H_SYNC, H_BACK, H_ACTIVE);
  localparam int V_TOTAL = lineTotal(V_FRONT, V_SYNC, V_BACK, V_ACTIVE);
  localparam int X_START = activeStart(H_FRONT, H_SYNC, H_BACK);
  localparam int Y_START = activeStart(V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] HS_BEGIN  = CNT_W'(H_FRONT);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN  = CNT_W'(V_FRONT);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] X_BEGIN   = CNT_W'(X_START);
  localparam logic [CNT_W-1:0] X_END     = CNT_W'(X_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] REQ_BEGIN = CNT_W'(X_START - 1);
  localparam logic [CNT_W-1:0] REQ_END   = CNT_W'(X_START + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_BEGIN   = CNT_W'(Y_START);
  localparam logic [CNT_W-1:0] Y_END     = CNT_W'(Y_START + V_ACTIVE);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(Y_START + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LOAD_A    = CNT_W'(LOAD_H_POS);
  localparam logic [CNT_W-1:0] LOAD_B    = CNT_W'(LOAD_H_POS + 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic             HS_ON     = 1'(HSYNC_POL);
  localparam logic             VS_ON     = 1'(VSYNC_POL);

  if (H_TOTAL >= (1 << CNT_W)) begin : gHTotalTooWide
    $error("H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL >= (1 << CNT_W)) begin : gVTotalTooWide
    $error("V_TOTAL does not fit in CNT_W bits");
  end
  if ((H_ACTIVE % 4 != 0) || (V_ACTIVE % 4 != 0)) begin : gActiveNotMul4
    $error("H_ACTIVE and V_ACTIVE must be multiples of 4");
  end
  if (LOAD_H_POS + 1 >= X_START - 1) begin : gLoadTooLate
    $error("load/clear pulse must finish before the first FIFO read");
  end

  logic [CNT_W-1:0]   hCnt, vCnt, hNext, vNext, zoomMask, vlineSet;
  logic [1:0]         zoomShiftR;
  logic               hActive, vActive, active, loadPix, reqSet, loadWin, loadSet, clearSet;
  logic               hSyncP1, vSyncP1, activeP1;
  logic [COLOR_W-1:0] pixRP1, pixGP1, pixBP1;

  vga_hv_counter #(
    .CNT_W   (CNT_W),
    .FRAME_W (FRAME_W),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) uCounter (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .oH          (hCnt),
    .oV          (vCnt),
    .oHNext      (hNext),
    .oVNext      (vNext),
    .oFrameStart (oFRAME_START),
    .oFrameCnt   (oFRAME_CNT)
  );

  // Raster decode; load/clear look at the next position so they line up with H.
  always_comb begin
    zoomMask = (ONE << zoomShiftR) - ONE;
    hActive  = (hCnt >= X_BEGIN) && (hCnt < X_END);
    vActive  = (vCnt >= Y_BEGIN) && (vCnt < Y_END);
    active   = hActive && vActive;
    loadPix  = active && (((hCnt - X_BEGIN) & zoomMask) == '0);
    reqSet   = vActive && (hCnt >= REQ_BEGIN) && (hCnt < REQ_END)
               && (((hCnt - REQ_BEGIN) & zoomMask) == '0);
    loadWin  = (hNext == LOAD_A) || (hNext == LOAD_B);
    clearSet = loadWin && (vNext == '0);
    loadSet  = 1'b0;
    vlineSet = '0;
    if (vNext == ONE) begin
      loadSet  = loadWin;
      vlineSet = '0;
    end else if ((vNext >= Y_BEGIN) && (vNext < Y_LAST)) begin
      // Each source line is fetched 2^z times because the reads consume it.
      loadSet  = loadWin;
      vlineSet = (vNext - Y_BEGIN + ONE) >> zoomShiftR;
    end else begin
      loadSet  = 1'b0;
      vlineSet = '0;
    end
  end

  // Zoom latch and first pipeline stage (syncs, active flag, pixel register).
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      zoomShiftR <= 2'd0;
      hSyncP1    <= ~HS_ON;
      vSyncP1    <= ~VS_ON;
      activeP1   <= 1'b0;
      pixRP1     <= '0;
      pixGP1     <= '0;
      pixBP1     <= '0;
    end else begin
      if ((hCnt == '0) && (vCnt == '0)) begin
        zoomShiftR <= zoomShift(zoomModeT'(iZOOM_MODE));
      end else begin
        zoomShiftR <= zoomShiftR;
      end
      hSyncP1  <= ((hCnt >= HS_BEGIN) && (hCnt < HS_END)) ? HS_ON : ~HS_ON;
      vSyncP1  <= ((vCnt >= VS_BEGIN) && (vCnt < VS_END)) ? VS_ON : ~VS_ON;
      activeP1 <= active;
      if (loadPix) begin
        pixRP1 <= iData_R;
        pixGP1 <= iData_G;
        pixBP1 <= iData_B;
      end else begin
        pixRP1 <= pixRP1;
        pixGP1 <= pixGP1;
        pixBP1 <= pixBP1;
      end
    end
  end

  // Second pipeline stage and FIFO handshakes.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oVGA_H_SYNC      <= ~HS_ON;
      oVGA_V_SYNC      <= ~VS_ON;
      oVGA_BLANK_N     <= 1'b0;
      oVGA_R           <= '0;
      oVGA_G           <= '0;
      oVGA_B           <= '0;
      oFIFO_REQ        <= 1'b0;
      oFIFO_LOAD_REQ   <= 1'b0;
      oFIFO_LOAD_VLINE <= '0;
      oFIFO_CLEAR      <= 1'b1;
    end else begin
      oVGA_H_SYNC      <= hSyncP1;
      oVGA_V_SYNC      <= vSyncP1;
      oVGA_BLANK_N     <= activeP1;
      oVGA_R           <= activeP1 ? pixRP1 : '0;
      oVGA_G           <= activeP1 ? pixGP1 : '0;
      oVGA_B           <= activeP1 ? pixBP1 : '0;
      oFIFO_REQ        <= reqSet;
      oFIFO_LOAD_REQ   <= loadSet;
      oFIFO_LOAD_VLINE <= vlineSet;
      oFIFO_CLEAR      <= clearSet;
    end
  end

  assign oFIFO_RCLK  = ~iCLK;
  assign oVGA_CLK    = ~iCLK;
  assign oVGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Scoreboard bench for vga_timing_engine on a 16x8 raster with a counting FIFO model.
module tb_vga_timing_engine;

  // Hand-derived raster: H 2/3/3/8, V 1/2/1/4, HSYNC active low.
  localparam int HT = 16, VT = 8;
  localparam int HS_B = 2, HS_E = 5, VS_B = 1, VS_E = 3;
  localparam int XS = 8, XE = 16, YS = 4, YE = 8;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [1:0]  iZOOM_MODE;
  logic [7:0]  iData_R = 8'd0, iData_G = 8'd0, iData_B = 8'd0;
  logic        oFIFO_RCLK, oFIFO_REQ, oFIFO_LOAD_REQ, oFIFO_CLEAR;
  logic [12:0] oFIFO_LOAD_VLINE;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
  logic        oVGA_H_SYNC, oVGA_V_SYNC, oVGA_SYNC_N, oVGA_BLANK_N, oVGA_CLK, oFRAME_START;
  logic [1:0]  oFRAME_CNT;

  always #5 iCLK = ~iCLK;

  vga_timing_engine #(
    .COLOR_W(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .H_ACTIVE(8),
    .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .V_ACTIVE(4),
    .HSYNC_POL(0), .VSYNC_POL(1), .LOAD_H_POS(2), .CNT_W(13), .FRAME_W(2)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iZOOM_MODE(iZOOM_MODE),
    .iData_R(iData_R), .iData_G(iData_G), .iData_B(iData_B),
    .oFIFO_RCLK(oFIFO_RCLK), .oFIFO_REQ(oFIFO_REQ), .oFIFO_LOAD_REQ(oFIFO_LOAD_REQ),
    .oFIFO_LOAD_VLINE(oFIFO_LOAD_VLINE), .oFIFO_CLEAR(oFIFO_CLEAR),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC), .oVGA_SYNC_N(oVGA_SYNC_N),
    .oVGA_BLANK_N(oVGA_BLANK_N), .oVGA_CLK(oVGA_CLK),
    .oFRAME_START(oFRAME_START), .oFRAME_CNT(oFRAME_CNT)
  );

  typedef struct packed {
    logic       hs, vs, bl;
    logic [7:0] r, g, b;
  } videoT;

  typedef struct packed {
    videoT       vid;
    logic        req, ld, clr, fs;
    logic [12:0] vl;
    logic [1:0]  fc;
  } expT;

  localparam videoT RST_V = '{hs: 1'b1, vs: 1'b0, bl: 1'b0, r: 8'd0, g: 8'd0, b: 8'd0};

  expT expQ[$];
  expT monE;
  int  vectors = 0;
  int  miscompares = 0;

  int    hM = 0, vM = 0, zM = 0, fcM = 0, rdPtr = 0;
  videoT vid1 = RST_V, vid2 = RST_V;
  logic  req1 = 1'b0, fs1 = 1'b0;

  function automatic int shiftOf(input logic [1:0] m);
    case (m)
      2'd1:    return 1;
      2'd2:    return 2;
      default: return 0;
    endcase
  endfunction

  // Expected video for a raster position: pixel value is the FIFO read index since CLEAR.
  function automatic videoT videoOf(input int h, input int v, input int z);
    videoT o;
    int    px;
    o.hs = (h >= HS_B && h < HS_E) ? 1'b0 : 1'b1;
    o.vs = (v >= VS_B && v < VS_E) ? 1'b1 : 1'b0;
    o.bl = (h >= XS && h < XE && v >= YS && v < YE) ? 1'b1 : 1'b0;
    px   = (v - YS) * (8 >> z) + ((h - XS) >> z);
    o.r  = o.bl ? 8'(px) : 8'd0;
    o.g  = o.bl ? (8'(px) ^ 8'h5A) : 8'd0;
    o.b  = o.bl ? (8'(px) + 8'd100) : 8'd0;
    return o;
  endfunction

  function automatic logic reqOf(input int h, input int v, input int z);
    return (v >= YS && v < YE && h >= XS - 1 && h < XE - 1 && ((h - XS + 1) % (1 << z)) == 0);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  // One clock: drive inputs, advance the reference raster, queue this cycle's expectation.
  task automatic step(input logic rst, input logic [1:0] zm);
    expT  e;
    int   hO, vO;
    logic ldWin;
    iRST_N     = rst;
    iZOOM_MODE = zm;
    @(posedge iCLK);
    #1;
    if (!rst) begin
      hM = 0; vM = 0; zM = 0; fcM = 0;
      vid1 = RST_V; vid2 = RST_V; req1 = 1'b0; fs1 = 1'b0;
    end else begin
      hO   = hM;
      vO   = vM;
      vid2 = vid1;
      vid1 = videoOf(hO, vO, zM);
      req1 = reqOf(hO, vO, zM);
      fs1  = (hO == 0 && vO == 0);
      if (fs1) begin
        fcM = (fcM + 1) % 4;
        zM  = shiftOf(zm);
      end
      hM = (hO == HT - 1) ? 0 : hO + 1;
      if (hO == HT - 1) vM = (vO == VT - 1) ? 0 : vO + 1;
    end
    ldWin  = (hM == 2 || hM == 3);
    e.vid  = vid2;
    e.req  = req1;
    e.fs   = fs1;
    e.fc   = 2'(fcM);
    e.clr  = !rst ? 1'b1 : (ldWin && vM == 0);
    e.ld   = !rst ? 1'b0 : (ldWin && (vM == 1 || (vM >= YS && vM < YE - 1)));
    e.vl   = (vM == 1) ? 13'd0 : 13'((vM + 1 - YS) >> zM);
    expQ.push_back(e);
  endtask

  // FIFO model: CLEAR rewinds, each REQ returns the next count on the read clock.
  initial begin
    forever begin
      @(negedge iCLK);
      if (oFIFO_CLEAR === 1'b1) begin
        rdPtr = 0;
      end else if (oFIFO_REQ === 1'b1) begin
        iData_R = 8'(rdPtr);
        iData_G = 8'(rdPtr) ^ 8'h5A;
        iData_B = 8'(rdPtr) + 8'd100;
        rdPtr++;
      end
    end
  end

  // Monitor: pop one expectation per presented cycle and compare.
  always @(negedge iCLK) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      vectors++;
      chk("hsync",  int'(oVGA_H_SYNC),    int'(monE.vid.hs));
      chk("vsync",  int'(oVGA_V_SYNC),    int'(monE.vid.vs));
      chk("blank_n", int'(oVGA_BLANK_N),  int'(monE.vid.bl));
      chk("red",    int'(oVGA_R),         int'(monE.vid.r));
      chk("green",  int'(oVGA_G),         int'(monE.vid.g));
      chk("blue",   int'(oVGA_B),         int'(monE.vid.b));
      chk("fifo_req", int'(oFIFO_REQ),    int'(monE.req));
      chk("load_req", int'(oFIFO_LOAD_REQ), int'(monE.ld));
      chk("fifo_clear", int'(oFIFO_CLEAR), int'(monE.clr));
      chk("frame_start", int'(oFRAME_START), int'(monE.fs));
      chk("frame_cnt", int'(oFRAME_CNT),  int'(monE.fc));
      chk("sync_n", int'(oVGA_SYNC_N),    0);
      if (monE.ld) chk("load_vline", int'(oFIFO_LOAD_VLINE), int'(monE.vl));
    end
  end

  initial begin
    iRST_N     = 1'b0;
    iZOOM_MODE = 2'd0;
    repeat (3) step(1'b0, 2'd0);
    // Two frames at 1x.
    repeat (2 * HT * VT) step(1'b1, 2'd0);
    // 2x frame; switch request to 4x at V=5 must not disturb it.
    for (int i = 0; i < HT * VT && !(hM == 0 && vM == 5); i++) step(1'b1, 2'd1);
    for (int i = 0; i < HT * VT && !(hM == 0 && vM == 0); i++) step(1'b1, 2'd2);
    // Next frame runs at 4x; reset it mid-line at H=9, V=5.
    for (int i = 0; i < HT * VT && !(hM == 9 && vM == 5); i++) step(1'b1, 2'd2);
    step(1'b0, 2'd2);
    // Reserved zoom behaves as 1x; five frames wrap the 2-bit frame counter.
    repeat (5 * HT * VT) step(1'b1, 2'd3);
    @(negedge iCLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
